// File: rtl/vga_scan_out.sv
// 640x480 raster scan with 1-based pixel coordinates, sync/blank delayed to meet the
// image generator's colour latency, and frame pacing pulses.
module vga_scan_out #(
   parameter int H_ACTIVE      = 640,
   parameter int H_FP          = 16,
   parameter int H_SYNC        = 96,
   parameter int H_BP          = 48,
   parameter int V_ACTIVE      = 480,
   parameter int V_FP          = 10,
   parameter int V_SYNC        = 2,
   parameter int V_BP          = 33,
   parameter int COLOR_LATENCY = 0
) (
   input  logic        CLOCK_25,
   input  logic        reset,
   output logic [11:0] x,
   output logic [11:0] y,
   input  logic [2:0]  color,
   output logic [7:0]  VGA_R,
   output logic [7:0]  VGA_G,
   output logic [7:0]  VGA_B,
   output logic        VGA_HS,
   output logic        VGA_VS,
   output logic        VGA_BLANK_N,
   output logic        VGA_SYNC_N,
   output logic        frame_start,
   output logic        frame_end
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
   localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
   localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
   localparam logic [11:0] HS_START   = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_END     = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] VS_START   = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_END     = 12'(V_ACTIVE + V_FP + V_SYNC);

   logic [11:0] h_cnt_reg, h_cnt_next;
   logic [11:0] v_cnt_reg, v_cnt_next;
   logic        active_raw, hs_raw, vs_raw;

   logic [11:0] x_reg, y_reg;
   logic        frame_start_reg, frame_end_reg;

   // Index 0 is registered alongside x/y; index COLOR_LATENCY feeds the pin register.
   logic [COLOR_LATENCY:0] hs_pipe_reg, vs_pipe_reg, act_pipe_reg;

   logic [2:0]  rgb_reg;
   logic        hs_out_reg, vs_out_reg, blank_n_reg;

   always_comb begin
      h_cnt_next = h_cnt_reg + 12'd1;
      v_cnt_next = v_cnt_reg;
      if (h_cnt_reg == H_LAST) begin
         h_cnt_next = 12'd0;
         if (v_cnt_reg == V_LAST) v_cnt_next = 12'd0;
         else                     v_cnt_next = v_cnt_reg + 12'd1;
      end
      active_raw = (h_cnt_reg < H_ACT_END) && (v_cnt_reg < V_ACT_END);
      hs_raw     = !((h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END));
      vs_raw     = !((v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END));
   end

   always_ff @(posedge CLOCK_25) begin
      if (reset) begin
         h_cnt_reg       <= 12'd0;
         v_cnt_reg       <= 12'd0;
         x_reg           <= 12'd0;
         y_reg           <= 12'd0;
         frame_start_reg <= 1'b0;
         frame_end_reg   <= 1'b0;
         hs_pipe_reg     <= '1;
         vs_pipe_reg     <= '1;
         act_pipe_reg    <= '0;
         rgb_reg         <= 3'b000;
         hs_out_reg      <= 1'b1;
         vs_out_reg      <= 1'b1;
         blank_n_reg     <= 1'b0;
      end else begin
         h_cnt_reg       <= h_cnt_next;
         v_cnt_reg       <= v_cnt_next;
         x_reg           <= active_raw ? h_cnt_reg + 12'd1 : 12'd0;
         y_reg           <= active_raw ? v_cnt_reg + 12'd1 : 12'd0;
         frame_start_reg <= (h_cnt_reg == 12'd0) && (v_cnt_reg == 12'd0);
         frame_end_reg   <= (h_cnt_reg == 12'd0) && (v_cnt_reg == V_ACT_END);
         hs_pipe_reg[0]  <= hs_raw;
         vs_pipe_reg[0]  <= vs_raw;
         act_pipe_reg[0] <= active_raw;
         for (int i = 1; i <= COLOR_LATENCY; i++) begin
            hs_pipe_reg[i]  <= hs_pipe_reg[i-1];
            vs_pipe_reg[i]  <= vs_pipe_reg[i-1];
            act_pipe_reg[i] <= act_pipe_reg[i-1];
         end
         // Colour arrives now for the coordinates the delayed controls describe.
         rgb_reg     <= act_pipe_reg[COLOR_LATENCY] ? color : 3'b000;
         hs_out_reg  <= hs_pipe_reg[COLOR_LATENCY];
         vs_out_reg  <= vs_pipe_reg[COLOR_LATENCY];
         blank_n_reg <= act_pipe_reg[COLOR_LATENCY];
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_dac
         assign VGA_R[gi] = rgb_reg[2];
         assign VGA_G[gi] = rgb_reg[1];
         assign VGA_B[gi] = rgb_reg[0];
      end
   endgenerate

   assign x           = x_reg;
   assign y           = y_reg;
   assign frame_start = frame_start_reg;
   assign frame_end   = frame_end_reg;
   assign VGA_HS      = hs_out_reg;
   assign VGA_VS      = vs_out_reg;
   assign VGA_BLANK_N = blank_n_reg;
   assign VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_scan_out.sv
// Randomized colour and resets on a shrunken raster; a position-based model feeds a
// scoreboard queue that a separate monitor drains every clock.
module tb_vga_scan_out;

   localparam int HA = 16, HF = 3, HS = 5, HB = 4;
   localparam int VA = 10, VF = 2, VS = 2, VB = 3;
   localparam int LAT = 2;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;
   localparam int MID_POS = 7 * HT + HA + HF + 2;
   localparam int N_CYC = 2000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  color = 3'b000;
   logic [11:0] x, y;
   logic [7:0]  vga_r, vga_g, vga_b;
   logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n;
   logic        frame_start, frame_end;

   always #5 clk = ~clk;

   vga_scan_out #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .COLOR_LATENCY(LAT)
   ) dut (
      .CLOCK_25(clk), .reset(reset), .x(x), .y(y), .color(color),
      .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
      .VGA_HS(vga_hs), .VGA_VS(vga_vs), .VGA_BLANK_N(vga_blank_n),
      .VGA_SYNC_N(vga_sync_n), .frame_start(frame_start), .frame_end(frame_end)
   );

   typedef struct packed {
      logic [11:0] x;
      logic [11:0] y;
      logic        fs;
      logic        fe;
      logic        hs;
      logic        vs;
      logic        bn;
      logic [7:0]  r;
      logic [7:0]  g;
      logic [7:0]  b;
   } exp_t;

   exp_t sb_q[$];
   int   rst_hist[$];
   int   pos_hist[$];
   int   cnt = 0;
   int   checks = 0;
   int   errors = 0;
   int   mon_cyc = 0;
   int   fs_seen = 0;
   int   fs_expected = 0;

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s at monitor cycle %0d: got %0d expected %0d", name, mon_cyc, got, want);
      end
   endtask

   // Model one clock edge: position-in-frame arithmetic, with reset restarting at 0.
   task automatic model_step(input bit r, input logic [2:0] c);
      exp_t e;
      int   s1, n, p, h, v;
      bit   act, inact;
      rst_hist.push_back(int'(r));
      if (r) begin
         cnt = 0;
         s1  = -1;
      end else begin
         s1  = cnt;
         cnt = (cnt + 1) % FT;
      end
      pos_hist.push_back(s1);

      e = '0;
      if (s1 >= 0) begin
         h   = s1 % HT;
         v   = s1 / HT;
         act = (h < HA) && (v < VA);
         e.x  = act ? 12'(h + 1) : 12'd0;
         e.y  = act ? 12'(v + 1) : 12'd0;
         e.fs = (s1 == 0);
         e.fe = (s1 == VA * HT);
      end
      if (e.fs) fs_expected++;

      n = rst_hist.size();
      inact = (n < LAT + 2);
      if (!inact)
         for (int k = n - LAT - 2; k < n; k++)
            if (rst_hist[k] != 0) inact = 1'b1;
      e.hs = 1'b1;
      e.vs = 1'b1;
      if (!inact) begin
         p   = pos_hist[n - LAT - 2];
         h   = p % HT;
         v   = p / HT;
         act = (h < HA) && (v < VA);
         e.hs = !((h >= HA + HF) && (h < HA + HF + HS));
         e.vs = !((v >= VA + VF) && (v < VA + VF + VS));
         e.bn = act;
         e.r  = (act && c[2]) ? 8'hFF : 8'h00;
         e.g  = (act && c[1]) ? 8'hFF : 8'h00;
         e.b  = (act && c[0]) ? 8'hFF : 8'h00;
      end
      sb_q.push_back(e);
   endtask

   // Monitor: one expected record per clock edge, compared 1 ns after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            mon_cyc++;
            if (frame_start) fs_seen++;
            chk("x", int'(x), int'(e.x));
            chk("y", int'(y), int'(e.y));
            chk("frame_start", int'(frame_start), int'(e.fs));
            chk("frame_end", int'(frame_end), int'(e.fe));
            chk("VGA_HS", int'(vga_hs), int'(e.hs));
            chk("VGA_VS", int'(vga_vs), int'(e.vs));
            chk("VGA_BLANK_N", int'(vga_blank_n), int'(e.bn));
            chk("VGA_R", int'(vga_r), int'(e.r));
            chk("VGA_G", int'(vga_g), int'(e.g));
            chk("VGA_B", int'(vga_b), int'(e.b));
            chk("VGA_SYNC_N", int'(vga_sync_n), 0);
         end
      end
   end

   // Stimulus: 3 reset cycles, one reset inside hsync mid-frame, rare random resets.
   initial begin
      bit mid_done;
      bit r;
      mid_done = 1'b0;
      for (int i = 0; i < N_CYC; i++) begin
         if (i < 3) r = 1'b1;
         else if (!mid_done && cnt == MID_POS) begin
            r = 1'b1;
            mid_done = 1'b1;
         end else r = ($urandom_range(0, 899) == 0);
         reset = r;
         color = 3'($urandom);
         model_step(r, color);
         @(negedge clk);
      end
      reset = 1'b0;
      for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
      chk("scoreboard_drained", sb_q.size(), 0);
      chk("frame_start_count", fs_seen, fs_expected);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_scan_out.md
# vga_scan_out

Display-timing and pixel-output stage for the Pong display path. Scans a 640x480@60 Hz raster from `CLOCK_25`, drives the 1-based `x`/`y` pixel coordinates consumed by the image generator, and accepts its 3-bit `color` back. It delays sync and blank by the generator's latency so that sync, blank and colour reach the VGA DAC pins aligned. It also emits per-frame pulses for game-logic pacing.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, horizontal sync width (clocks)
- `H_BP`, 48, horizontal back porch (clocks)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `COLOR_LATENCY`, 0, clocks from `x`/`y` change to matching `color` valid; legal range 0..3

Ports:
- `CLOCK_25` in 1: pixel clock, 25 MHz. Single clock domain; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `x` out 12: pixel column, 1..H_ACTIVE while active, 0 otherwise.
- `y` out 12: pixel row, 1..V_ACTIVE while active, 0 otherwise.
- `color` in 3: pixel colour from the image generator; [2]=R, [1]=G, [0]=B.
- `VGA_R`, `VGA_G`, `VGA_B` out 8 each: DAC data; each is the corresponding `color` bit replicated ×8.
- `VGA_HS` out 1: horizontal sync, active-low.
- `VGA_VS` out 1: vertical sync, active-low.
- `VGA_BLANK_N` out 1: high during active video.
- `VGA_SYNC_N` out 1: constant 0.
- `frame_start` out 1: one-cycle pulse, coincident at the `x`/`y` ports with x=1, y=1.
- `frame_end` out 1: one-cycle pulse, coincident at the `x`/`y` ports with the first cycle of line V_ACTIVE (first blank line).

## Operation
- Counters:
  - `h_cnt` runs 0..H_TOTAL-1, where H_TOTAL = sum of the H_* parameters (800).
  - `v_cnt` runs 0..V_TOTAL-1 (525) and increments when `h_cnt` wraps.
  - Both wrap to 0 after their maximum.
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
  - `x` = h_cnt+1 and `y` = v_cnt+1 when active; both are 0 when not active.
  - If the line is inactive (v_cnt ≥ V_ACTIVE), both are 0 for the whole line.
- Raw sync (before alignment):
  - hs_raw low while H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_raw low while V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491), for the whole line.
- Alignment pipeline:
  - hs_raw, vs_raw and active are registered alongside `x`/`y`.
  - They are then delayed by COLOR_LATENCY further stages.
  - The output register samples `color` and the delayed controls on the same edge.
- Blanking: when the delayed active is 0, `VGA_R/G/B` = 0 regardless of `color`.
- Widths:
  - Counters are 12 bits.
  - All comparisons are unsigned and use parameter-derived constants only; no runtime arithmetic beyond +1.

## Timing
- Reset value of every output, applied on the edge where `reset`=1:

  | Output | Reset value |
  |---|---|
  | `x`, `y` | 0 |
  | `VGA_HS`, `VGA_VS` | 1 |
  | `VGA_BLANK_N` | 0 |
  | `VGA_R/G/B` | 0 |
  | `frame_start`, `frame_end` | 0 |
  | `VGA_SYNC_N` | 0 |

- Reset also clears internal state:
  - Counters go to (0,0).
  - The delay line is filled with inactive values (hs=1, vs=1, active=0).
- Cycle after reset deasserts:
  - The counter holds (0,0) during the first cycle with reset low.
  - `x`=1, `y`=1 and `frame_start`=1 appear on the following cycle.
- Latency:
  - `x`/`y` lag the counters by 1 clock.
  - Pins (RGB, HS, VS, BLANK_N) lag `x`/`y` by COLOR_LATENCY+1 clocks.
- Frame period: exactly 420000 clocks between successive `frame_start` pulses. `frame_end` occurs 384000 clocks after `frame_start`.
- Reset mid-frame: takes effect on the next edge and restarts the scan from (0,0); no partial sync pulse may extend past reset.
- The counter wraps at h=799/v=524 to (0,0) in one step, with no extra cycle.

## Test plan
- Reset values: hold `reset` 3 cycles → all outputs at their reset values. Release → on the second cycle after release, `x`=1, `y`=1, `frame_start`=1 for exactly 1 cycle.
- Line scan, COLOR_LATENCY=0: over one line, `x` must read 1..640 on consecutive cycles, then 0 for 160 cycles. `y` must be constant. `VGA_HS` must be low for exactly 96 cycles, starting 657 cycles after `x`=1 is seen at the pins' reference point.
- Frame scan: count clocks → 420000 between `frame_start` pulses; `frame_end` is 384000 after `frame_start`. `VGA_VS` must be low for exactly 1600 clocks, starting at line 490.
- Alignment, COLOR_LATENCY=2:
  - Bench drives `color` = {x[0], y[0], 1} delayed 2 clocks.
  - Each active pin cycle must show R/G/B = 0xFF/0x00 patterns matching the `x`/`y` of 3 clocks earlier.
  - Blanked cycles must show RGB=0 even with `color`=3'b111.
- Blank override: drive `color`=3'b111 constantly → RGB nonzero only when `VGA_BLANK_N`=1. `VGA_BLANK_N` high for exactly 640 clocks per visible line and 0 on lines 481..525.
- Mid-frame reset: assert `reset` for 1 cycle at v=200, h=700 (inside hsync) → `VGA_HS` returns to 1 after the reset edge's pipeline flush. The scan restarts, and `frame_start` follows 2 cycles after deassert.
